memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Stage-4 wrapper around `data_memory` that turns an execute-stage memory request into `data_memory` controls, then aligns and extends the returned word for writeback. It generates byte enables and replicated store data on the request side. On the response side it extracts and sign- or zero-extends byte, half and word loads, and registers the result toward stage 5. It also detects misaligned and illegal accesses and honours the pipeline's stall and flush controls.

## Interface
Parameters: none. Address width and the `word` type come from `common/definitions.vh`.

Ports:
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request present from the EX register.
- `in_is_load` in 1, `in_is_store` in 1: access kind.
- `in_funct3` in 3: RV32I load/store funct3.
- `in_addr` in word: byte address.
- `in_store_data` in word: rs2 value.
- `in_rd` in 5: destination register.
- `stall` in 1: hold all state; issue nothing.
- `flush` in 1: kill the in-flight request and all registered state.
- `mem_read` out 1, `mem_write` out 1, `mem_addr` out word, `mem_write_to` out 4, `mem_write_value` out word: drive `data_memory`.
- `mem_read_value` in word: `data_memory` output.
- `out_valid` out 1, `out_is_load` out 1, `out_rd` out 5, `out_load_data` out word: registered result to stage 5.
- `out_fault` out 1, `out_fault_misaligned` out 1, `out_fault_addr` out word: registered exception report.

## Operation
- **Request side (combinational from `in_*`).**
  - `mem_addr = in_addr`.
  - An access is legal when exactly one of `in_is_load` / `in_is_store` is set.
    - Loads: funct3 must be in {LB 0, LH 1, LW 2, LBU 4, LHU 5}.
    - Stores: funct3 must be in {SB 0, SH 1, SW 2}.
  - Misaligned: half with `addr[0]=1`; word with `addr[1:0]!=0`.
  - `go = in_valid & ~stall & ~flush & legal & ~misaligned`.
  - `mem_read = go & load`; `mem_write = go & store`.
- **Store enables and data.**
  - SB: `write_to = 4'b0001 << addr[1:0]`; `write_value = {4{rs2[7:0]}}`.
  - SH: `write_to = 4'b0011 << addr[1:0]`; `write_value = {2{rs2[15:0]}}`.
  - SW: `write_to = 4'b1111`; `write_value = rs2`.
  - When not writing, `write_to = 0`.
- **Response register (R).**
  - Loads on edge when `~stall`: `valid`, `is_load`, `funct3`, `addr[1:0]`, `rd`, fault flags, full address.
  - `flush` clears `R.valid` and takes priority over `stall`.
- **Load extract (combinational from R and `mem_read_value`).**
  - LB / LBU: byte `addr[1:0]`, sign- or zero-extended.
  - LH / LHU: half `addr[1]`, sign- or zero-extended.
  - LW: full word.
  - Non-load or faulted entry: 0.
- **Output register (O).**
  - Loads from R on edge when `~stall`.
  - `flush` clears `out_valid` and `out_fault`.
  - A faulted entry drives `out_valid=1`, `out_fault=1`, `out_load_data=0`.
    - `out_fault_misaligned=1` for misaligned, 0 for illegal.
  - Invalid `in_valid=0` requests propagate as bubbles.
- **Reset.** Clears R and O: all valids, faults and data go to 0, `out_rd=0`. `mem_read` and `mem_write` are combinational and 0 while `in_valid=0`.

## Timing
- **Latency.** Request in cycle N:
  - memory access at edge N→N+1;
  - `mem_read_value` valid in N+1;
  - `out_*` valid in N+2.
  - Throughput is one access per cycle.
- **`data_memory` holds `read_value` when not read.** While `stall=1`, `mem_read=0`, so R, O and `mem_read_value` all hold. Extract output is stable across any stall length.
- **Stall in cycle N.** The request is not issued and must be re-presented by upstream. A store never writes twice.
- **Flush in cycle N.** No memory write in N. R and O are invalid after the edge.
- **Flush and stall together.** Flush wins.
- **Reset mid-operation.** Valids clear at the next edge. A store presented in the reset cycle is still gated only by `go`. Upstream must hold `in_valid=0` during reset.
- **Load then store to the same address in consecutive cycles.** Each sees memory in program order; no forwarding is needed.

## Structure
- **`common/definitions.vh`.** Add `` `funct3_lb/lh/lw/lbu/lhu/sb/sh/sw `` defines there. Reuse `` `byte0..`byte3 `` and `word`.
- **Sub-module `load_extract`.** Purely combinational: `funct3`, `addr[1:0]`, `word` in; extended `word` out. It is instantiated once. The rest of the block (store encode, fault detect, R, O) lives in the top module.

## Test plan
- **Stores then word loads.** SB 0xA5 @0x101, SH 0xBEEF @0x102, SW 0x12345678 @0x104 → `write_to` 0010, 1100, 1111. LW @0x100 yields 0xBEEFA500 at N+2; LW @0x104 yields 0x12345678.
- **Sub-word loads of 0x80FF7F01 @0x10.** LB@0x13 → 0xFFFFFF80; LBU@0x13 → 0x00000080; LH@0x12 → 0xFFFF80FF; LHU@0x10 → 0x00007F01.
- **Misaligned and illegal.** LW@0x102, SH@0x101 → `mem_write=0`, `out_fault=1`, `out_fault_misaligned=1`, `out_fault_addr` correct. Load funct3=3 → `out_fault=1`, `misaligned=0`.
- **Stall.** LW @0x104 issued, then `stall` for 3 cycles → `out_load_data` stays 0x12345678, no `mem_read` during the stall, result advances once the stall drops.
- **Flush.** SW 0xDEADBEEF @0x20 with `flush=1` → no write; later LW @0x20 returns the old value. Flush with R valid → `out_valid=0` next cycle.
- **Reset.** Assert `reset` with R and O valid → all outputs 0 after one edge; back-to-back loads one cycle after release return correct data.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared types, funct3 encodings and access-classification helpers for the
// stage-4 memory access unit.
package memory_access_unit_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Request register: one entry captured from the EX register.
    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic       fault;
        logic       misaligned;
        logic [2:0] funct3;
        logic [4:0] rd;
        word_t      addr;
    } req_reg_t;

    // Output register presented to stage 5.
    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [4:0] rd;
        word_t      load_data;
        logic       fault;
        logic       misaligned;
        word_t      fault_addr;
    } out_reg_t;

    // Exactly one of load/store, with a funct3 that RV32I defines for it.
    function automatic logic access_legal(input logic ld, input logic st,
                                          input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (ld && !st)
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        else if (st && !ld)
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = a[0];
            2'd2:    mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_access_unit_load_extract.sv
// Selects the addressed byte/half/word from the memory read word and
// sign- or zero-extends it according to the load funct3.
module load_extract
    import memory_access_unit_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension; unknown funct3 yields zero.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'b0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'b0, half_sel};
            F3_LW:   data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Stage-4 memory access unit: encodes data_memory controls from the EX
// request, tracks the access through a request register (R) while memory
// responds, then extracts/extends load data into the output register (O).
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [WORD_W-1:0] in_addr,
    input  logic [WORD_W-1:0] in_store_data,
    input  logic [4:0]        in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [3:0]        mem_write_to,
    output logic [WORD_W-1:0] mem_write_value,
    input  logic [WORD_W-1:0] mem_read_value,
    output logic              out_valid,
    output logic              out_is_load,
    output logic [4:0]        out_rd,
    output logic [WORD_W-1:0] out_load_data,
    output logic              out_fault,
    output logic              out_fault_misaligned,
    output logic [WORD_W-1:0] out_fault_addr
);

    logic     legal;
    logic     misaligned;
    logic     go;
    req_reg_t r_q, r_d;
    out_reg_t o_q, o_d;
    word_t    ext_word;
    word_t    extract_data;

    // Classify the incoming request and decide whether memory is touched.
    always_comb begin
        legal      = access_legal(in_is_load, in_is_store, in_funct3);
        misaligned = access_misaligned(in_funct3, in_addr[1:0]);
        go         = in_valid & ~stall & ~flush & legal & ~misaligned;
    end

    assign mem_addr  = in_addr;
    assign mem_read  = go & in_is_load;
    assign mem_write = go & in_is_store;

    // Byte enables and lane-replicated store data; enables are zero unless writing.
    always_comb begin
        mem_write_to    = 4'b0000;
        mem_write_value = '0;
        if (mem_write) begin
            case (in_funct3)
                F3_SB: begin
                    mem_write_to    = 4'b0001 << in_addr[1:0];
                    mem_write_value = {4{in_store_data[7:0]}};
                end
                F3_SH: begin
                    mem_write_to    = 4'b0011 << in_addr[1:0];
                    mem_write_value = {2{in_store_data[15:0]}};
                end
                default: begin
                    mem_write_to    = 4'b1111;
                    mem_write_value = in_store_data;
                end
            endcase
        end
    end

    // R next state: flush kills the entry, stall holds, otherwise capture.
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d.valid      = 1'b0;
            r_d.fault      = 1'b0;
            r_d.misaligned = 1'b0;
        end else if (!stall) begin
            r_d.valid      = in_valid;
            r_d.is_load    = in_is_load;
            r_d.fault      = in_valid & (~legal | misaligned);
            r_d.misaligned = in_valid & legal & misaligned;
            r_d.funct3     = in_funct3;
            r_d.rd         = in_rd;
            r_d.addr       = in_addr;
        end
    end

    // R register.
    always_ff @(posedge clock) begin
        if (reset) r_q <= '0;
        else       r_q <= r_d;
    end

    load_extract u_load_extract (
        .funct3_i  (r_q.funct3),
        .addr_lo_i (r_q.addr[1:0]),
        .word_i    (mem_read_value),
        .data_o    (ext_word)
    );

    // Only a clean, valid load carries data; stores and faults report zero.
    always_comb begin
        extract_data = (r_q.valid & r_q.is_load & ~r_q.fault) ? ext_word : '0;
    end

    // O next state: same flush/stall priority as R.
    always_comb begin
        o_d = o_q;
        if (flush) begin
            o_d.valid      = 1'b0;
            o_d.fault      = 1'b0;
            o_d.misaligned = 1'b0;
        end else if (!stall) begin
            o_d.valid      = r_q.valid;
            o_d.is_load    = r_q.is_load;
            o_d.rd         = r_q.rd;
            o_d.load_data  = extract_data;
            o_d.fault      = r_q.valid & r_q.fault;
            o_d.misaligned = r_q.valid & r_q.misaligned;
            o_d.fault_addr = (r_q.valid & r_q.fault) ? r_q.addr : '0;
        end
    end

    // O register.
    always_ff @(posedge clock) begin
        if (reset) o_q <= '0;
        else       o_q <= o_d;
    end

    assign out_valid            = o_q.valid;
    assign out_is_load          = o_q.is_load;
    assign out_rd               = o_q.rd;
    assign out_load_data        = o_q.load_data;
    assign out_fault            = o_q.fault;
    assign out_fault_misaligned = o_q.misaligned;
    assign out_fault_addr       = o_q.fault_addr;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: a byte-array reference model
// predicts each result at issue time; a monitor checks results as they appear.
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_store_data;
    logic [4:0]  in_rd;
    logic        stall, flush;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_value, mem_read_value;
    logic [3:0]  mem_write_to;
    logic        out_valid, out_is_load, out_fault, out_fault_misaligned;
    logic [4:0]  out_rd;
    logic [31:0] out_load_data, out_fault_addr;

    memory_access_unit dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
        .in_rd(in_rd), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_to(mem_write_to), .mem_write_value(mem_write_value),
        .mem_read_value(mem_read_value),
        .out_valid(out_valid), .out_is_load(out_is_load), .out_rd(out_rd),
        .out_load_data(out_load_data), .out_fault(out_fault),
        .out_fault_misaligned(out_fault_misaligned), .out_fault_addr(out_fault_addr)
    );

    always #5 clock = ~clock;

    // data_memory stand-in: registered read that holds when not read.
    logic [31:0] mem_w [256];
    logic        mem_clr;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_w[i] <= '0;
            mem_read_value <= '0;
        end else begin
            if (mem_read) mem_read_value <= mem_w[mem_addr[9:2]];
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    if (mem_write_to[i]) mem_w[mem_addr[9:2]][8*i +: 8] <= mem_write_value[8*i +: 8];
        end
    end

    typedef struct {
        logic        fault;
        logic        mis;
        logic [31:0] addr;
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] ref_mem [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, " out_fault"}, {31'b0, out_fault}, {31'b0, e.fault});
        chk({tag, " out_fault_misaligned"}, {31'b0, out_fault_misaligned}, {31'b0, e.mis});
        if (e.fault) chk({tag, " out_fault_addr"}, out_fault_addr, e.addr);
        chk({tag, " out_is_load"}, {31'b0, out_is_load}, {31'b0, e.is_load});
        chk({tag, " out_rd"}, {27'b0, out_rd}, {27'b0, e.rd});
        chk({tag, " out_load_data"}, out_load_data, e.data);
    endtask

    // One cycle of stimulus; predicts memory controls and the eventual result.
    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic stl, input logic fl, input logic rst);
        exp_t        e;
        bit          legal, mis, go;
        int          sz, idx;
        logic [3:0]  exp_en;
        logic [31:0] exp_wv;
        longint      val;
        @(posedge clock);
        #2;
        in_valid = v; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = a; in_store_data = d; in_rd = rd; stall = stl; flush = fl; reset = rst;
        legal = (ld ^ st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                 : (f3 inside {3'd0, 3'd1, 3'd2}));
        sz    = 1 << f3[1:0];
        mis   = legal && ((int'(a[1:0]) % sz) != 0);
        go    = v && !stl && !fl && legal && !mis;
        exp_en = '0;
        exp_wv = '0;
        val    = 0;
        if (go && st) begin
            for (int b = 0; b < sz; b++) begin
                idx = int'(a[1:0]) + b;
                exp_en[idx] = 1'b1;
                ref_mem[(int'(a[9:0]) + b) % 1024] = d[8*b +: 8];
            end
            for (int lane = 0; lane < 4; lane++) exp_wv[8*lane +: 8] = d[8*(lane % sz) +: 8];
        end
        if (go && ld) begin
            for (int b = 0; b < sz; b++)
                val = val | (longint'(ref_mem[(int'(a[9:0]) + b) % 1024]) << (8*b));
            if (!f3[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1)))
                val = val - (longint'(1) << (8*sz));
        end
        e.fault   = !legal || mis;
        e.mis     = legal && mis;
        e.addr    = a;
        e.is_load = ld;
        e.rd      = rd;
        e.data    = (go && ld) ? val[31:0] : 32'h0;
        if (rst || fl) q.delete();
        else if (v && !stl) q.push_back(e);
        #1;
        chk("mem_read", {31'b0, mem_read}, {31'b0, go && ld});
        chk("mem_write", {31'b0, mem_write}, {31'b0, go && st});
        chk("mem_addr", mem_addr, a);
        chk("mem_write_to", {28'b0, mem_write_to}, {28'b0, exp_en});
        if (go && st) chk("mem_write_value", mem_write_value, exp_wv);
    endtask

    task automatic ld_req(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        drive(1, 1, 0, f3, a, 32'h0, rd, 0, 0, 0);
    endtask

    task automatic st_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drive(1, 0, 1, f3, a, d, 5'd0, 0, 0, 0);
    endtask

    task automatic bubble();
        drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    endtask

    // Monitor: pops an expectation whenever O loads a valid entry, checks hold
    // during stall and the cleared state after reset/flush.
    initial begin : monitor
        exp_t e, last;
        bit   have_last;
        logic s, f, r;
        have_last = 0;
        forever begin
            @(posedge clock);
            s = stall; f = flush; r = reset;
            #1;
            if (r) begin
                chk("reset out_valid", {31'b0, out_valid}, 32'd0);
                chk("reset out_fault", {31'b0, out_fault}, 32'd0);
                chk("reset out_fault_misaligned", {31'b0, out_fault_misaligned}, 32'd0);
                chk("reset out_is_load", {31'b0, out_is_load}, 32'd0);
                chk("reset out_rd", {27'b0, out_rd}, 32'd0);
                chk("reset out_load_data", out_load_data, 32'd0);
                chk("reset out_fault_addr", out_fault_addr, 32'd0);
                have_last = 0;
            end else if (f) begin
                chk("flush out_valid", {31'b0, out_valid}, 32'd0);
                chk("flush out_fault", {31'b0, out_fault}, 32'd0);
                have_last = 0;
            end else if (!s) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: out_valid=1 rd=%0d with no pending request", out_rd);
                        have_last = 0;
                    end else begin
                        e = q.pop_front();
                        cmp("result", e);
                        last = e;
                        have_last = 1;
                    end
                end else begin
                    have_last = 0;
                end
            end else if (have_last) begin
                cmp("stall_hold", last);
            end
        end
    end

    initial begin : stimulus
        logic        v, ld, st, stl, fl;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        reset = 1; mem_clr = 1;
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
        in_addr = 0; in_store_data = 0; in_rd = 0; stall = 0; flush = 0;
        repeat (2) @(posedge clock);
        #2;
        mem_clr = 0;

        // stores then word loads
        st_req(3'd0, 32'h101, 32'h000000A5);
        st_req(3'd1, 32'h102, 32'h0000BEEF);
        st_req(3'd2, 32'h104, 32'h12345678);
        ld_req(3'd2, 32'h100, 5'd1);
        ld_req(3'd2, 32'h104, 5'd2);

        // sub-word loads
        st_req(3'd2, 32'h10, 32'h80FF7F01);
        ld_req(3'd0, 32'h13, 5'd3);
        ld_req(3'd4, 32'h13, 5'd4);
        ld_req(3'd1, 32'h12, 5'd5);
        ld_req(3'd5, 32'h10, 5'd6);

        // misaligned and illegal
        ld_req(3'd2, 32'h102, 5'd7);
        st_req(3'd1, 32'h101, 32'h00001234);
        ld_req(3'd3, 32'h40, 5'd8);

        // stall with O holding a load result, then with R holding one
        ld_req(3'd2, 32'h104, 5'd9);
        bubble();
        repeat (3) drive(1, 1, 0, 3'd2, 32'h100, 32'h0, 5'd10, 1, 0, 0);
        ld_req(3'd2, 32'h100, 5'd11);
        repeat (2) drive(1, 0, 1, 3'd2, 32'h104, 32'hFFFFFFFF, 5'd0, 1, 0, 0);
        ld_req(3'd1, 32'h102, 5'd12);

        // flush: killed store, then flush with R valid, then flush+stall
        drive(1, 0, 1, 3'd2, 32'h20, 32'hDEADBEEF, 5'd0, 0, 1, 0);
        ld_req(3'd2, 32'h20, 5'd13);
        ld_req(3'd2, 32'h104, 5'd14);
        drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 1, 0);
        bubble();
        ld_req(3'd2, 32'h10, 5'd15);
        drive(1, 0, 1, 3'd2, 32'h20, 32'hCAFEF00D, 5'd0, 1, 1, 0);
        ld_req(3'd2, 32'h20, 5'd16);
        bubble();

        // reset with R and O valid, then back-to-back loads
        ld_req(3'd2, 32'h104, 5'd17);
        ld_req(3'd2, 32'h100, 5'd18);
        drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
        ld_req(3'd2, 32'h104, 5'd19);
        ld_req(3'd2, 32'h100, 5'd20);
        bubble();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 7) != 0);
            ld = $urandom_range(0, 1);
            st = !ld;
            if ($urandom_range(0, 15) == 0)
                f3 = ld ? 3'(3 + 3 * $urandom_range(0, 1)) : 3'($urandom_range(3, 7));
            else if (ld)
                f3 = 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4));
            else
                f3 = 3'($urandom_range(0, 2));
            a  = $urandom & 32'h3FF;
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'd3) a = a & ~(32'(sz) - 1);
            stl = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(v, ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)), stl, fl, 0);
        end

        repeat (4) bubble();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results never appeared, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
